// File: rtl/ucode_fetch_stage.sv
// ucode_fetch_stage: writable control store, microword pipeline register and decode into am2910 sequencer inputs.
// Optional macro PARITY_EN adds a per-word even-parity bit and a sticky par_err flag.
module ucode_fetch_stage #(
    parameter int ABITS = 12,
    parameter int DBITS = 12,
    parameter int WBITS = DBITS + 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ABITS-1:0] y,
    input  logic             hold,
    input  logic             map_sel,
    input  logic             vect_sel,
    input  logic [DBITS-1:0] map_addr,
    input  logic [DBITS-1:0] vect_addr,
    input  logic [6:0]       status_in,
    input  logic             status_ld,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [WBITS-1:0] wr_data,
    output logic [3:0]       I,
    output logic             CCEN_BAR,
    output logic             CC_BAR,
    output logic             CI,
    output logic             RLD_BAR,
    output logic [DBITS-1:0] D,
    output logic             valid,
    output logic             par_err
);

    // CONT with condition disabled, CI=1 and no counter load
    localparam logic [WBITS-1:0] NOP_WORD =
        {{DBITS{1'b0}}, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 4'd14};

`ifdef PARITY_EN
    localparam int MBITS = WBITS + 1;
`else
    localparam int MBITS = WBITS;
`endif

    logic [MBITS-1:0] mem_q [2**ABITS];
    logic [MBITS-1:0] wr_word;
    logic [MBITS-1:0] rd_word;
    logic [WBITS-1:0] pipe_q;
    logic [WBITS-1:0] pipe_d;
    logic             valid_q;
    logic [6:0]       status_q;
    logic             par_bad;
    logic [7:0]       cond_vec;
    logic             cond;

`ifdef PARITY_EN
    assign wr_word = {^wr_data, wr_data};
    assign par_bad = ^rd_word;
`else
    assign wr_word = wr_data;
    assign par_bad = 1'b0;
`endif

    // Same-cycle write to the fetched address bypasses the array
    assign rd_word = (wr_en && (wr_addr == y)) ? wr_word : mem_q[y];
    assign pipe_d  = par_bad ? NOP_WORD : rd_word[WBITS-1:0];

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q   <= NOP_WORD;
            valid_q  <= 1'b0;
            status_q <= '0;
        end else begin
            if (!hold) begin
                pipe_q  <= pipe_d;
                valid_q <= 1'b1;
            end
            if (status_ld) begin
                status_q <= status_in;
            end
        end
    end

`ifdef PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_q <= 1'b0;
        end else if (!hold && par_bad) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    // cc_sel==7 selects a constant-true condition
    assign cond_vec = {1'b1, status_q};
    assign cond     = cond_vec[pipe_q[7:5]];

    assign I        = pipe_q[3:0];
    assign CCEN_BAR = pipe_q[4];
    assign CC_BAR   = ~(cond ^ pipe_q[8]);
    assign CI       = pipe_q[9];
    assign RLD_BAR  = pipe_q[10];
    assign D        = vect_sel ? vect_addr : (map_sel ? map_addr : pipe_q[WBITS-1:11]);
    assign valid    = valid_q;

endmodule

// File: tb/tb_ucode_fetch_stage.sv
// Self-checking bench for ucode_fetch_stage: directed test-plan scenarios followed by random traffic vs a reference model.
module tb_ucode_fetch_stage;
    localparam int ABITS = 12;
    localparam int DBITS = 12;
    localparam int WBITS = DBITS + 11;

    logic             clk = 1'b0;
    logic             reset;
    logic [ABITS-1:0] y;
    logic             hold;
    logic             map_sel;
    logic             vect_sel;
    logic [DBITS-1:0] map_addr;
    logic [DBITS-1:0] vect_addr;
    logic [6:0]       status_in;
    logic             status_ld;
    logic             wr_en;
    logic [ABITS-1:0] wr_addr;
    logic [WBITS-1:0] wr_data;
    logic [3:0]       I;
    logic             CCEN_BAR;
    logic             CC_BAR;
    logic             CI;
    logic             RLD_BAR;
    logic [DBITS-1:0] D;
    logic             valid;
    logic             par_err;

    always #5 clk = ~clk;

    ucode_fetch_stage #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .clk(clk), .reset(reset), .y(y), .hold(hold),
        .map_sel(map_sel), .vect_sel(vect_sel), .map_addr(map_addr), .vect_addr(vect_addr),
        .status_in(status_in), .status_ld(status_ld),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .I(I), .CCEN_BAR(CCEN_BAR), .CC_BAR(CC_BAR), .CI(CI), .RLD_BAR(RLD_BAR),
        .D(D), .valid(valid), .par_err(par_err)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WBITS-1:0] mk(input logic [3:0] i, input logic ccen, input logic [2:0] sel,
                                            input logic inv, input logic ci, input logic rld,
                                            input logic [DBITS-1:0] br);
        return {br, rld, ci, inv, sel, ccen, i};
    endfunction

    // Reference model: control store contents, pipeline word and flags
    logic [WBITS-1:0] m_mem [int];
    bit               m_bad [int];
    logic [WBITS-1:0] m_pipe;
    bit               m_valid;
    logic [6:0]       m_status;
    bit               m_perr;
    logic [WBITS-1:0] nop_word;

    task automatic model_step();
        logic [WBITS-1:0] w;
        bit bad;
        if (reset) begin
            m_pipe   = nop_word;
            m_valid  = 0;
            m_status = '0;
            m_perr   = 0;
        end else begin
            if (wr_en && wr_addr == y) begin
                w   = wr_data;
                bad = 0;
            end else begin
                w   = m_mem.exists(int'(y)) ? m_mem[int'(y)] : 'x;
                bad = m_bad.exists(int'(y)) && m_bad[int'(y)];
            end
            if (!hold) begin
                if (bad) begin
                    m_pipe = nop_word;
                    m_perr = 1;
                end else begin
                    m_pipe = w;
                end
                m_valid = 1;
            end
            if (status_ld) m_status = status_in;
            if (wr_en) begin
                m_mem[int'(wr_addr)] = wr_data;
                m_bad[int'(wr_addr)] = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int sel;
        int cond;
        int exp_ccbar;
        logic [DBITS-1:0] exp_d;
        sel  = int'(m_pipe[7:5]);
        cond = (sel == 7) ? 1 : ((int'(m_status) >> sel) & 1);
        exp_ccbar = (cond ^ int'(m_pipe[8])) == 1 ? 0 : 1;
        if (vect_sel)     exp_d = vect_addr;
        else if (map_sel) exp_d = map_addr;
        else              exp_d = m_pipe[WBITS-1:11];
        check({tag, ".I"},        32'(I),        32'(m_pipe[3:0]));
        check({tag, ".CCEN_BAR"}, 32'(CCEN_BAR), 32'(m_pipe[4]));
        check({tag, ".CC_BAR"},   32'(CC_BAR),   32'(exp_ccbar));
        check({tag, ".CI"},       32'(CI),       32'(m_pipe[9]));
        check({tag, ".RLD_BAR"},  32'(RLD_BAR),  32'(m_pipe[10]));
        check({tag, ".D"},        32'(D),        32'(exp_d));
        check({tag, ".valid"},    32'(valid),    32'(m_valid));
        check({tag, ".par_err"},  32'(par_err),  32'(m_perr));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        nop_word  = mk(4'd14, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, '0);
        m_pipe    = 'x;
        m_valid   = 0;
        m_status  = '0;
        m_perr    = 0;
        reset     = 1'b1;
        y         = '0;
        hold      = 1'b0;
        map_sel   = 1'b0;
        vect_sel  = 1'b0;
        map_addr  = '0;
        vect_addr = '0;
        status_in = '0;
        status_ld = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        cycle("rst0");
        cycle("rst1");

        // preload addresses 0..31 while the pipeline is held
        reset = 1'b0;
        hold  = 1'b1;
        wr_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            wr_addr = ABITS'(a);
            wr_data = WBITS'($urandom);
            cycle("preload");
        end
        wr_en = 1'b0;
        hold  = 1'b0;

        // reset for two clocks then idle
        reset = 1'b1;
        cycle("rst2");
        cycle("rst3");
        check("rst_I",        32'(I),        32'd14);
        check("rst_CCEN_BAR", 32'(CCEN_BAR), 32'd1);
        check("rst_CI",       32'(CI),       32'd1);
        check("rst_RLD_BAR",  32'(RLD_BAR),  32'd1);
        check("rst_D",        32'(D),        32'd0);
        check("rst_CC_BAR",   32'(CC_BAR),   32'd1);
        check("rst_valid",    32'(valid),    32'd0);
        reset = 1'b0;
        cycle("idle");
        check("idle_valid", 32'(valid), 32'd1);

        // write then fetch address 5
        wr_en   = 1'b1;
        wr_addr = 12'd5;
        wr_data = mk(4'd3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 12'h3A5);
        cycle("wr5");
        wr_en = 1'b0;
        y     = 12'd5;
        cycle("fetch5");
        check("fetch5_I",    32'(I),        32'd3);
        check("fetch5_CCEN", 32'(CCEN_BAR), 32'd0);
        check("fetch5_D",    32'(D),        32'h3A5);

        // write-through at address 9
        wr_en   = 1'b1;
        wr_addr = 12'd9;
        y       = 12'd9;
        wr_data = mk(4'd1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 12'h055);
        cycle("wthru");
        check("wthru_I", 32'(I), 32'd1);
        wr_en = 1'b0;
        y     = 12'd5;
        cycle("refetch5");
        y = 12'd9;
        cycle("refetch9");
        check("refetch9_I", 32'(I), 32'd1);

        // condition-code words at 10/11/12
        wr_en = 1'b1;
        wr_addr = 12'd10; wr_data = mk(4'd3, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 12'h010); cycle("wr10");
        wr_addr = 12'd11; wr_data = mk(4'd3, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 12'h011); cycle("wr11");
        wr_addr = 12'd12; wr_data = mk(4'd3, 1'b0, 3'd7, 1'b0, 1'b1, 1'b1, 12'h012); cycle("wr12");
        wr_en     = 1'b0;
        y         = 12'd10;
        status_ld = 1'b1;
        status_in = 7'b0000100;
        cycle("ld_status");
        status_ld = 1'b0;
        cycle("cc_sel2");
        check("cc_sel2_CC_BAR", 32'(CC_BAR), 32'd0);
        y = 12'd11;
        cycle("cc_inv");
        check("cc_inv_CC_BAR", 32'(CC_BAR), 32'd1);
        y         = 12'd12;
        status_ld = 1'b1;
        status_in = 7'b0000000;
        cycle("cc_sel7a");
        status_ld = 1'b0;
        cycle("cc_sel7b");
        check("cc_sel7_CC_BAR", 32'(CC_BAR), 32'd0);

        // hold and D mux
        y = 12'd5;
        cycle("pre_hold");
        hold = 1'b1;
        y    = 12'd9;
        cycle("hold");
        check("hold_I", 32'(I), 32'd3);
        map_sel  = 1'b1;
        map_addr = 12'h0C0;
        cycle("map");
        check("map_D", 32'(D), 32'h0C0);
        vect_sel  = 1'b1;
        vect_addr = 12'h7F0;
        cycle("vect");
        check("vect_D", 32'(D), 32'h7F0);
        hold     = 1'b0;
        map_sel  = 1'b0;
        vect_sel = 1'b0;

`ifdef PARITY_EN
        dut.mem_q[5][WBITS] = ~dut.mem_q[5][WBITS];
        m_bad[5] = 1;
        y = 12'd5;
        cycle("par5");
        check("par5_I",   32'(I),       32'd14);
        check("par5_err", 32'(par_err), 32'd1);
        y = 12'd9;
        cycle("par_sticky");
        check("par_sticky_err", 32'(par_err), 32'd1);
        reset = 1'b1;
        cycle("par_rst");
        check("par_rst_err", 32'(par_err), 32'd0);
        reset = 1'b0;
`endif

        // random traffic confined to the preloaded window
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            hold      = ($urandom_range(0, 3) == 0);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = ABITS'($urandom_range(0, 31));
            wr_data   = WBITS'($urandom);
            y         = ($urandom_range(0, 3) == 0) ? wr_addr : ABITS'($urandom_range(0, 31));
            status_ld = ($urandom_range(0, 2) == 0);
            status_in = 7'($urandom);
            map_sel   = ($urandom_range(0, 3) == 0);
            vect_sel  = ($urandom_range(0, 3) == 0);
            map_addr  = DBITS'($urandom);
            vect_addr = DBITS'($urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
